// File: rtl/mem_sched_pkg.sv
// Shared widths and FSM encoding for the memory load scheduler.
package mem_sched_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 64;

   typedef enum logic {
      DRAIN = 1'b0,
      RUN   = 1'b1
   } state_e;
endpackage

// File: rtl/mem_tag_fifo.sv
// Requester-ID FIFO for in-flight loads; memory returns in issue order, so the head tag
// names the owner of the next response.
module mem_tag_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 8,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic [PW:0]  count_o,
   output logic         empty_o,
   output logic         full_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [PW:0]   cnt_q;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end
endmodule

// File: rtl/mem_load_sched.sv
// Round-robin sharing of one memory load port among NREQ requesters; in-order responses
// are routed back by a tag FIFO. A post-reset DRAIN phase flushes stale memory responses.
module mem_load_sched
   import mem_sched_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int MAX_OUT   = 8,
   parameter int DRAIN_CYC = 100,
   localparam int TAGW     = $clog2(NREQ),
   localparam int OCW      = $clog2(MAX_OUT) + 1,
   localparam int CNT_W    = $clog2(DRAIN_CYC + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   output logic [NREQ-1:0]        req_ready,
   output logic [NREQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]      resp_data,
   output logic                   mem_load_enable,
   output logic [ADDR_W-1:0]      mem_load_addr,
   input  logic                   mem_load_ready,
   input  logic [DATA_W-1:0]      mem_load_data,
   output logic [OCW-1:0]         outstanding,
   output logic                   busy
);
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TAGW-1:0]   ptr_q, gnt_idx, head_tag;
   logic              gnt_vld, pop, fifo_empty, fifo_full;
   logic              en_q;
   logic [ADDR_W-1:0] addr_q;
   int                idx;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == DRAIN) begin
         if (cnt_q == '0) state_d = RUN;
         else             cnt_d   = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DRAIN;
         cnt_q   <= CNT_W'(DRAIN_CYC - 1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Scan starts at ptr_q; full occupancy blocks grants even if a pop happens this cycle.
   always_comb begin
      gnt_vld   = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      req_ready = '0;
      if (state_q == RUN && !fifo_full) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!gnt_vld && req_valid[idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = TAGW'(idx);
            end
         end
      end
      if (gnt_vld) req_ready[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q   <= 1'b0;
         addr_q <= '0;
         ptr_q  <= '0;
      end else begin
         en_q <= gnt_vld;
         if (gnt_vld) begin
            addr_q <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
            ptr_q  <= (gnt_idx == TAGW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   assign pop = (state_q == RUN) & mem_load_ready & ~fifo_empty;

   always_comb begin
      resp_valid = '0;
      if (pop) resp_valid[head_tag] = 1'b1;
   end

   mem_tag_fifo #(
      .W     (TAGW),
      .DEPTH (MAX_OUT)
   ) u_tag_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (gnt_vld),
      .data_i  (gnt_idx),
      .pop_i   (pop),
      .data_o  (head_tag),
      .count_o (outstanding),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign resp_data       = mem_load_data;
   assign mem_load_enable = en_q;
   assign mem_load_addr   = addr_q;
   assign busy            = (state_q == DRAIN);
endmodule

// File: tb/tb_mem_load_sched.sv
// Bench for mem_load_sched: 100-stage unreset memory model, queue-based reference model,
// a grant table after reset, then saturation, random traffic and a mid-flight reset.
module tb_mem_load_sched;
   localparam int NREQ = 4;
   localparam int MAX_OUT = 8;
   localparam int DRAIN_CYC = 100;
   localparam int LAT = 100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    req_valid = '0;
   logic [63:0]   req_addr = '0;
   logic [3:0]    req_ready, resp_valid;
   logic [63:0]   resp_data, mem_load_data;
   logic          mem_load_enable, mem_load_ready;
   logic [15:0]   mem_load_addr;
   logic [3:0]    outstanding;
   logic          busy;

   int nerr = 0;
   int nchk = 0;

   always #5 clk = ~clk;

   mem_load_sched #(.NREQ(NREQ), .MAX_OUT(MAX_OUT), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .mem_load_enable(mem_load_enable), .mem_load_addr(mem_load_addr),
      .mem_load_ready(mem_load_ready), .mem_load_data(mem_load_data),
      .outstanding(outstanding), .busy(busy)
   );

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endfunction

   function automatic logic [63:0] mem_fn(input logic [15:0] a);
      return {a, ~a, a ^ 16'h5a5a, 16'hc0de};
   endfunction

   // Memory load pipe without reset: sample at posedge, answer LAT edges later.
   bit        en_pipe [LAT];
   bit [15:0] addr_pipe [LAT];
   always @(posedge clk) begin
      en_pipe[0]   <= mem_load_enable;
      addr_pipe[0] <= mem_load_addr;
      for (int s = 1; s < LAT; s++) begin
         en_pipe[s]   <= en_pipe[s-1];
         addr_pipe[s] <= addr_pipe[s-1];
      end
   end
   assign mem_load_ready = en_pipe[LAT-1];
   assign mem_load_data  = mem_fn(addr_pipe[LAT-1]);

   // Reference model: queue of in-flight (id, addr), RR pointer, drain countdown.
   typedef struct {
      int          id;
      logic [15:0] addr;
   } ent_t;
   ent_t        mq[$];
   int          mptr = 0;
   int          mdrain = DRAIN_CYC;
   logic        men = 1'b0;
   logic [15:0] maddr = '0;

   always @(negedge clk) begin
      int g;
      logic [3:0] exp_rdy, exp_rv;
      if (!rst_n) begin
         chk("rst_busy", 64'(busy), 64'(1));
         chk("rst_enable", 64'(mem_load_enable), 64'(0));
         chk("rst_addr", 64'(mem_load_addr), 64'(0));
         chk("rst_outstanding", 64'(outstanding), 64'(0));
         chk("rst_ready", 64'(req_ready), 64'(0));
         chk("rst_resp_valid", 64'(resp_valid), 64'(0));
         mq.delete();
         mptr = 0; mdrain = DRAIN_CYC; men = 1'b0; maddr = '0;
      end else begin
         g = -1;
         exp_rdy = '0;
         exp_rv = '0;
         if (mdrain == 0 && mq.size() < MAX_OUT)
            for (int k = 0; k < NREQ; k++)
               if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
         if (g >= 0) exp_rdy[g] = 1'b1;
         if (mdrain == 0 && mem_load_ready && mq.size() > 0) exp_rv[mq[0].id] = 1'b1;
         chk("busy", 64'(busy), 64'(mdrain != 0));
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
         chk("mem_enable", 64'(mem_load_enable), 64'(men));
         chk("mem_addr", 64'(mem_load_addr), 64'(maddr));
         chk("outstanding", 64'(outstanding), 64'(mq.size()));
         if (exp_rv != 0) begin
            chk("resp_data", resp_data, mem_fn(mq[0].addr));
            void'(mq.pop_front());
         end
         men = (g >= 0);
         if (g >= 0) begin
            maddr = req_addr[16*g +: 16];
            mq.push_back('{id: g, addr: maddr});
            mptr = (g + 1) % NREQ;
         end
         if (mdrain > 0) mdrain--;
      end
   end

   typedef struct {
      logic [3:0] vld;
      logic [3:0] exp_rdy;
   } vec_t;
   vec_t tbl[9];

   task automatic wait_idle(input string nm);
      int n = 0;
      while (outstanding != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk(nm, 64'(outstanding), 64'(0));
   endtask

   initial begin
      tbl[0] = '{4'b0001, 4'b0001};
      tbl[1] = '{4'b0001, 4'b0001};
      tbl[2] = '{4'b1111, 4'b0010};
      tbl[3] = '{4'b0011, 4'b0001};
      tbl[4] = '{4'b1100, 4'b0100};
      tbl[5] = '{4'b1100, 4'b1000};
      tbl[6] = '{4'b0000, 4'b0000};
      tbl[7] = '{4'b1010, 4'b0010};
      tbl[8] = '{4'b0101, 4'b0100};

      req_addr = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (DRAIN_CYC) @(posedge clk);

      // Grant order from a fresh pointer; eight grants fill the FIFO.
      foreach (tbl[i]) begin
         @(posedge clk); #1;
         req_valid = tbl[i].vld;
         @(negedge clk);
         chk("tbl_ready", 64'(req_ready), 64'(tbl[i].exp_rdy));
      end
      @(posedge clk); #1;
      req_valid = 4'b1111;
      @(negedge clk);
      chk("full_block_ready", 64'(req_ready), 64'(0));
      chk("full_outstanding", 64'(outstanding), 64'(MAX_OUT));
      repeat (300) @(posedge clk);
      #1 req_valid = '0;
      wait_idle("idle_after_saturate");

      // Random traffic.
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         req_valid = 4'($urandom);
         for (int i = 0; i < NREQ; i++) req_addr[16*i +: 16] = 16'($urandom);
      end
      @(posedge clk); #1 req_valid = '0;
      wait_idle("idle_after_random");

      // Reset with five loads in flight; stale responses land during DRAIN.
      req_valid = 4'b1111;
      repeat (5) @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      chk("inflight_before_reset", 64'(outstanding), 64'(5));
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (DRAIN_CYC + 5) @(posedge clk);
      #1 req_valid = 4'b0100;
      req_addr[32 +: 16] = 16'h0bee;
      @(posedge clk); #1 req_valid = '0;
      begin
         int n = 0;
         @(negedge clk);
         while (resp_valid == 0 && n < 150) begin
            @(negedge clk);
            n++;
         end
         chk("post_reset_resp_id", 64'(resp_valid), 64'(4'b0100));
         chk("post_reset_resp_data", resp_data, mem_fn(16'h0bee));
      end
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
